// File: rtl/reg_writeback_if.sv
// rtl/reg_writeback_if.sv - pipeline and long-latency write buses into reg_writeback
// master drives results; slave is the writeback front end that returns ll_ready.
interface reg_writeback_if;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ll_valid;
   logic [4:0]  ll_addr;
   logic [31:0] ll_data;
   logic        ll_ready;

   modport master (
      output wb_valid, wb_addr, wb_data,
      output ll_valid, ll_addr, ll_data,
      input  ll_ready
   );

   modport slave (
      input  wb_valid, wb_addr, wb_data,
      input  ll_valid, ll_addr, ll_data,
      output ll_ready
   );
endinterface

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - register file write-port arbiter with long-latency FIFO, busy scoreboard and bypass
// Pipeline writes always win; queued mul/div results drain when the pipeline is idle.
module reg_writeback #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   reg_writeback_if.slave         bus,
   input  logic                   claim_valid,
   input  logic [4:0]             claim_addr,
   input  logic [4:0]             read_addr_1,
   input  logic [4:0]             read_addr_2,
   output logic                   busy_1,
   output logic                   busy_2,
   output logic                   fwd_valid_1,
   output logic                   fwd_valid_2,
   output logic [31:0]            fwd_data_1,
   output logic [31:0]            fwd_data_2,
   output logic                   wb_stall,
   output logic [4:0]             write_addr,
   output logic [31:0]            write_data,
   output logic                   write_enabled,
   output logic [$clog2(DEPTH):0] ll_count
);

   localparam int AW  = $clog2(DEPTH);
   localparam int AW1 = AW + 1;
   localparam int CW  = $clog2(STARVE_LIMIT + 1);
   localparam int CW1 = CW + 1;
   localparam logic [AW:0]   DEPTH_C = AW1'(DEPTH);
   localparam logic [CW:0]   LIMIT_W = CW1'(STARVE_LIMIT);
   localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

   logic [36:0]   mem_q [DEPTH];
   logic [36:0]   mem_d [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [31:0]   busy_q, busy_d;
   logic [CW-1:0] starve_q, starve_d;
   logic          wb_stall_q, wb_stall_d;
   logic          write_enabled_q, write_enabled_d;
   logic [4:0]    write_addr_q, write_addr_d;
   logic [31:0]   write_data_q, write_data_d;

   logic [AW:0]   count;
   logic          full, empty, push, pop;
   logic [4:0]    head_addr;
   logic [31:0]   head_data;
   logic          sel_valid, sel_we;
   logic [4:0]    sel_addr;
   logic [31:0]   sel_data;
   logic [CW:0]   starve_inc;
   logic [32:0]   fwd_1, fwd_2;

   // Newest-first bypass: this cycle's selected write, then the registered port.
   function automatic logic [32:0] fwd_lookup(
      input logic [4:0]  ra,
      input logic        s_we,
      input logic [4:0]  s_addr,
      input logic [31:0] s_data,
      input logic        r_we,
      input logic [4:0]  r_addr,
      input logic [31:0] r_data
   );
      fwd_lookup = '0;
      if (ra != 5'd0) begin
         if (s_we && s_addr == ra) begin
            fwd_lookup = {1'b1, s_data};
         end else if (r_we && r_addr == ra) begin
            fwd_lookup = {1'b1, r_data};
         end
      end
   endfunction

   always_comb begin
      count        = wr_ptr_q - rd_ptr_q;
      full         = (count == DEPTH_C);
      empty        = (count == '0);
      bus.ll_ready = !full && !rst;
      push         = bus.ll_valid && !full && !rst;
      head_addr    = mem_q[rd_ptr_q[AW-1:0]][36:32];
      head_data    = mem_q[rd_ptr_q[AW-1:0]][31:0];
      pop          = !bus.wb_valid && !empty;

      sel_valid = bus.wb_valid || !empty;
      sel_addr  = bus.wb_valid ? bus.wb_addr : head_addr;
      sel_data  = bus.wb_valid ? bus.wb_data : head_data;
      sel_we    = sel_valid && (sel_addr != 5'd0);
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = {bus.ll_addr, bus.ll_data};
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Clear before set so a same-cycle claim to the popped address keeps its bit.
   always_comb begin
      busy_d = busy_q;
      if (pop) begin
         busy_d[head_addr] = 1'b0;
      end
      if (claim_valid && claim_addr != 5'd0) begin
         busy_d[claim_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      starve_inc = {1'b0, starve_q} + 1'b1;
      starve_d   = '0;
      wb_stall_d = 1'b0;
      if (!empty && !pop) begin
         starve_d   = (starve_inc >= LIMIT_W) ? LIMIT_C : starve_inc[CW-1:0];
         wb_stall_d = (starve_inc >= LIMIT_W);
      end
   end

   always_comb begin
      write_enabled_d = sel_we;
      write_addr_d    = sel_valid ? sel_addr : write_addr_q;
      write_data_d    = sel_valid ? sel_data : write_data_q;
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         busy_q          <= '0;
         starve_q        <= '0;
         wb_stall_q      <= 1'b0;
         write_enabled_q <= 1'b0;
         write_addr_q    <= '0;
         write_data_q    <= '0;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         busy_q          <= busy_d;
         starve_q        <= starve_d;
         wb_stall_q      <= wb_stall_d;
         write_enabled_q <= write_enabled_d;
         write_addr_q    <= write_addr_d;
         write_data_q    <= write_data_d;
      end
   end

   always_comb begin
      fwd_1 = fwd_lookup(read_addr_1, sel_we, sel_addr, sel_data,
                         write_enabled_q, write_addr_q, write_data_q);
      fwd_2 = fwd_lookup(read_addr_2, sel_we, sel_addr, sel_data,
                         write_enabled_q, write_addr_q, write_data_q);
   end

   assign busy_1        = busy_q[read_addr_1] && !(pop && head_addr == read_addr_1);
   assign busy_2        = busy_q[read_addr_2] && !(pop && head_addr == read_addr_2);
   assign fwd_valid_1   = fwd_1[32];
   assign fwd_data_1    = fwd_1[31:0];
   assign fwd_valid_2   = fwd_2[32];
   assign fwd_data_2    = fwd_2[31:0];
   assign wb_stall      = wb_stall_q;
   assign write_enabled = write_enabled_q;
   assign write_addr    = write_addr_q;
   assign write_data    = write_data_q;
   assign ll_count      = count;

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - directed scoreboard bench for reg_writeback
// Stimulus queues expected register-file writes; a negedge monitor compares them.
module tb_reg_writeback;
   logic        clk = 1'b0;
   logic        rst;
   logic        claim_valid;
   logic [4:0]  claim_addr;
   logic [4:0]  read_addr_1, read_addr_2;
   logic        busy_1, busy_2, fwd_valid_1, fwd_valid_2, wb_stall, write_enabled;
   logic [31:0] fwd_data_1, fwd_data_2, write_data;
   logic [4:0]  write_addr;
   logic [2:0]  ll_count;

   int checks = 0;
   int errors = 0;
   logic [36:0] exp_q[$];

   reg_writeback_if bus ();

   reg_writeback #(.DEPTH(4), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .claim_valid(claim_valid), .claim_addr(claim_addr),
      .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
      .busy_1(busy_1), .busy_2(busy_2),
      .fwd_valid_1(fwd_valid_1), .fwd_valid_2(fwd_valid_2),
      .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
      .wb_stall(wb_stall), .write_addr(write_addr), .write_data(write_data),
      .write_enabled(write_enabled), .ll_count(ll_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_push(input logic [4:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   // Scoreboard monitor for the register-file write port.
   always @(negedge clk) begin
      if (write_enabled === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr %0d data %h expected none", write_addr, write_data);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            if ({write_addr, write_data} !== e) begin
               errors++;
               $display("FAIL write_port: got addr %0d data %h expected addr %0d data %h",
                        write_addr, write_data, e[36:32], e[31:0]);
            end
         end
      end
   end

   always @(negedge clk) begin
      assert (!(bus.wb_valid && wb_stall)) else begin
         errors++;
         $display("FAIL wb_during_stall: got wb_valid 1 expected 0 while wb_stall");
      end
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      rst = 1'b1;
      bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
      bus.ll_valid = 1'b0; bus.ll_addr = '0; bus.ll_data = '0;
      claim_valid = 1'b0; claim_addr = '0;
      read_addr_1 = '0; read_addr_2 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ll_ready", 32'(bus.ll_ready), 32'd0);
      chk("rst_wb_stall", 32'(wb_stall), 32'd0);
      chk("rst_write_en", 32'(write_enabled), 32'd0);
      chk("rst_ll_count", 32'(ll_count), 32'd0);

      next_cycle(); rst = 1'b0;
      @(negedge clk);
      chk("ll_ready_out_of_rst", 32'(bus.ll_ready), 32'd1);
      chk("rst_write_addr", 32'(write_addr), 32'd0);
      chk("rst_write_data", write_data, 32'd0);

      // Pipeline write and both forwarding windows
      next_cycle();
      bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
      read_addr_1 = 5'd5; exp_push(5'd5, 32'hDEADBEEF);
      @(negedge clk);
      chk("fwd_sel_valid", 32'(fwd_valid_1), 32'd1);
      chk("fwd_sel_data", fwd_data_1, 32'hDEADBEEF);
      next_cycle(); bus.wb_valid = 1'b0;
      @(negedge clk);
      chk("fwd_port_valid", 32'(fwd_valid_1), 32'd1);
      chk("fwd_port_data", fwd_data_1, 32'hDEADBEEF);
      next_cycle();
      @(negedge clk);
      chk("fwd_expired", 32'(fwd_valid_1), 32'd0);
      chk("write_idle", 32'(write_enabled), 32'd0);

      // Claim then long-latency result
      next_cycle(); claim_valid = 1'b1; claim_addr = 5'd8; read_addr_1 = 5'd8;
      @(negedge clk);
      chk("busy_not_yet", 32'(busy_1), 32'd0);
      next_cycle(); claim_valid = 1'b0;
      bus.ll_valid = 1'b1; bus.ll_addr = 5'd8; bus.ll_data = 32'h1234;
      exp_push(5'd8, 32'h1234);
      @(negedge clk);
      chk("busy_claimed", 32'(busy_1), 32'd1);
      chk("no_fall_through", 32'(fwd_valid_1), 32'd0);
      next_cycle(); bus.ll_valid = 1'b0;
      @(negedge clk);
      chk("busy_pop_bypass", 32'(busy_1), 32'd0);
      chk("fwd_pop_valid", 32'(fwd_valid_1), 32'd1);
      chk("fwd_pop_data", fwd_data_1, 32'h1234);
      chk("count_one", 32'(ll_count), 32'd1);
      next_cycle();
      @(negedge clk);
      chk("pop_write_addr", 32'(write_addr), 32'd8);
      chk("busy_cleared", 32'(busy_1), 32'd0);
      chk("count_zero", 32'(ll_count), 32'd0);

      // Fill FIFO under continuous pipeline writes, then drain
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         bus.wb_valid = 1'b1; bus.wb_addr = 5'd10; bus.wb_data = 32'hA0 + 32'(i);
         exp_push(5'd10, 32'hA0 + 32'(i));
         bus.ll_valid = 1'b1; bus.ll_addr = 5'd20 + 5'(i); bus.ll_data = 32'hE0 + 32'(i);
         @(negedge clk);
         chk("fill_ready", 32'(bus.ll_ready), 32'd1);
      end
      next_cycle();
      bus.wb_data = 32'hA4; exp_push(5'd10, 32'hA4); bus.ll_valid = 1'b0;
      @(negedge clk);
      chk("full_ready", 32'(bus.ll_ready), 32'd0);
      chk("full_count", 32'(ll_count), 32'd4);
      chk("stall_not_yet", 32'(wb_stall), 32'd0);
      next_cycle(); bus.wb_valid = 1'b0;
      for (int i = 0; i < 4; i++) exp_push(5'd20 + 5'(i), 32'hE0 + 32'(i));
      @(negedge clk);
      chk("stall_high", 32'(wb_stall), 32'd1);
      chk("full_pop_ready", 32'(bus.ll_ready), 32'd0);
      chk("full_pop_count", 32'(ll_count), 32'd4);
      next_cycle();
      @(negedge clk);
      chk("stall_cleared", 32'(wb_stall), 32'd0);
      chk("ready_back", 32'(bus.ll_ready), 32'd1);
      chk("drain_count", 32'(ll_count), 32'd3);
      repeat (3) next_cycle();
      @(negedge clk);
      chk("drained", 32'(ll_count), 32'd0);

      // Address zero: no write, no forward, no busy
      next_cycle();
      bus.wb_valid = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFFFFFF;
      claim_valid = 1'b1; claim_addr = 5'd0; read_addr_1 = 5'd0; read_addr_2 = 5'd0;
      @(negedge clk);
      chk("zero_fwd_1", 32'(fwd_valid_1), 32'd0);
      chk("zero_fwd_2", 32'(fwd_valid_2), 32'd0);
      next_cycle(); bus.wb_valid = 1'b0; claim_valid = 1'b0;
      @(negedge clk);
      chk("zero_no_write", 32'(write_enabled), 32'd0);
      chk("zero_not_busy", 32'(busy_1), 32'd0);

      // Same-cycle claim and pop on addr 3
      next_cycle();
      bus.ll_valid = 1'b1; bus.ll_addr = 5'd3; bus.ll_data = 32'h33;
      read_addr_2 = 5'd3; exp_push(5'd3, 32'h33);
      @(negedge clk);
      chk("addr3_idle", 32'(busy_2), 32'd0);
      next_cycle(); bus.ll_valid = 1'b0; claim_valid = 1'b1; claim_addr = 5'd3;
      @(negedge clk);
      chk("addr3_fwd_valid", 32'(fwd_valid_2), 32'd1);
      chk("addr3_fwd_data", fwd_data_2, 32'h33);
      next_cycle(); claim_valid = 1'b0;
      @(negedge clk);
      chk("claim_wins", 32'(busy_2), 32'd1);
      chk("addr3_written", 32'(write_addr), 32'd3);

      // Reset with queued entries and busy bits
      next_cycle();
      claim_valid = 1'b1; claim_addr = 5'd12;
      bus.wb_valid = 1'b1; bus.wb_addr = 5'd14; bus.wb_data = 32'h1414; exp_push(5'd14, 32'h1414);
      bus.ll_valid = 1'b1; bus.ll_addr = 5'd12; bus.ll_data = 32'hC12;
      read_addr_1 = 5'd12; read_addr_2 = 5'd13;
      next_cycle();
      claim_addr = 5'd13; bus.wb_data = 32'h1415; exp_push(5'd14, 32'h1415);
      bus.ll_addr = 5'd13; bus.ll_data = 32'hC13;
      @(negedge clk);
      chk("pre_rst_busy", 32'(busy_1), 32'd1);
      next_cycle();
      rst = 1'b1; bus.wb_valid = 1'b0; bus.ll_valid = 1'b0; claim_valid = 1'b0;
      @(negedge clk);
      chk("in_rst_ready", 32'(bus.ll_ready), 32'd0);
      chk("pre_rst_count", 32'(ll_count), 32'd2);
      chk("pre_rst_busy_2", 32'(busy_2), 32'd1);
      next_cycle(); rst = 1'b0;
      @(negedge clk);
      chk("post_rst_count", 32'(ll_count), 32'd0);
      chk("post_rst_busy_1", 32'(busy_1), 32'd0);
      chk("post_rst_busy_2", 32'(busy_2), 32'd0);
      chk("post_rst_write", 32'(write_enabled), 32'd0);
      next_cycle(); read_addr_1 = 5'd3;
      @(negedge clk);
      chk("post_rst_busy_3", 32'(busy_1), 32'd0);
      repeat (4) next_cycle();
      @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
